// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, default
// constants and the word-alignment helper.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;
    localparam logic [31:0] PC_STEP              = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_adder.sv
// Sequential-PC adder shared with the rest of the core; wraps modulo 2^W.
module fetch_pc_unit_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [W-1:0] sum
);

    assign sum = in1 + in2;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM,
// registered output stage to decode plus a one-entry skid buffer.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pc_plus4;
    logic         kill_reg, kill_next;
    logic         req_valid_reg, req_valid_next;
    logic         if_valid_reg, if_valid_next;
    logic [31:0]  if_pc_reg, if_pc_next;
    logic [31:0]  if_instr_reg, if_instr_next;
    logic         skid_valid_reg, skid_valid_next;
    logic [31:0]  skid_pc_reg, skid_pc_next;
    logic [31:0]  skid_instr_reg, skid_instr_next;
    logic         req_fire;
    logic         consumed;

    fetch_pc_unit_adder #(.W(32)) u_pc_adder (
        .in1 (pc_reg),
        .in2 (PC_STEP),
        .sum (pc_plus4)
    );

    assign req_fire = req_valid_reg && imem_req_ready;
    assign consumed = if_valid_reg && if_ready;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        kill_next       = kill_reg;
        if_valid_next   = if_valid_reg;
        if_pc_next      = if_pc_reg;
        if_instr_next   = if_instr_reg;
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;

        if (consumed) begin
            if_valid_next = 1'b0;
            if_instr_next = NOP_INSTR;
        end

        case (state_reg)
            S_REQ: begin
                if (req_fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    if (kill_reg) begin
                        kill_next = 1'b0;
                    end else begin
                        pc_next = pc_plus4;
                        if (!if_valid_reg || consumed) begin
                            if_valid_next = 1'b1;
                            if_pc_next    = pc_reg;
                            if_instr_next = imem_rsp_data;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_pc_next    = pc_reg;
                            skid_instr_next = imem_rsp_data;
                            state_next      = S_FULL;
                        end
                    end
                end
            end
            S_FULL: begin
                if (consumed) begin
                    if_valid_next   = 1'b1;
                    if_pc_next      = skid_pc_reg;
                    if_instr_next   = skid_instr_reg;
                    skid_valid_next = 1'b0;
                    state_next      = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        // Redirect overrides everything decided above.
        if (redirect_valid) begin
            pc_next         = word_align(redirect_target);
            if_valid_next   = 1'b0;
            if_instr_next   = NOP_INSTR;
            skid_valid_next = 1'b0;
            case (state_reg)
                S_REQ: begin
                    if (req_fire) begin
                        kill_next  = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        kill_next  = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end

        // An unaccepted request withdrawn by redirect stays low for one cycle.
        req_valid_next = (state_next == S_REQ) &&
                         !(redirect_valid && (state_reg == S_REQ) && !req_fire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_VECTOR;
            kill_reg       <= 1'b0;
            req_valid_reg  <= 1'b0;
            if_valid_reg   <= 1'b0;
            if_pc_reg      <= 32'h0000_0000;
            if_instr_reg   <= NOP_INSTR;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= 32'h0000_0000;
            skid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            kill_reg       <= kill_next;
            req_valid_reg  <= req_valid_next;
            if_valid_reg   <= if_valid_next;
            if_pc_reg      <= if_pc_next;
            if_instr_reg   <= if_instr_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = pc_reg;
    assign if_valid       = if_valid_reg;
    assign if_pc          = if_pc_reg;
    assign if_instr       = if_instr_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: behavioural imem with programmable latency,
// decode handshake log, immediate-assertion checks.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } ent_t;

    ent_t        cons_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          fire_cnt = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    fetch_pc_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_ready        (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] image(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: logs decode handshakes, advances the memory model, returns #1 after the edge.
    task automatic tick();
        logic        fire;
        logic [31:0] faddr;
        fire  = imem_req_valid && imem_req_ready;
        faddr = imem_req_addr;
        if (if_valid && if_ready) begin
            cons_q.push_back('{if_pc, if_instr, cyc});
            $display("[TB] cyc %0d consumed pc=%h instr=%h", cyc, if_pc, if_instr);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (fire) begin
            fire_cnt++;
            pend_addr = faddr;
            pend_cnt  = mem_lat;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = image(pend_addr);
            end
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend_cnt       = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cons_q.delete();
        fire_cnt = 0;
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (cons_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(cons_q.size() >= n), 32'd1);
    endtask

    task automatic chk_ent(input string tag, input int idx,
                           input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        if (cons_q.size() > idx) begin
            chk({tag, "_pc"}, cons_q[idx].pc, exp_pc);
            chk({tag, "_instr"}, cons_q[idx].instr, exp_instr);
        end else begin
            chk({tag, "_missing"}, 32'(cons_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        if_ready        = 1'b1;

        // Reset values
        @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0000_0000);
        chk("rst_if_instr", if_instr, 32'h0000_0013);

        // 1: sequential fetch, 1-cycle memory
        mem_lat = 1;
        do_reset();
        chk("t1_req_before_edge", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t1_req_first_edge", 32'(imem_req_valid), 32'd1);
        chk("t1_addr_first", imem_req_addr, 32'h0000_0000);
        wait_log("t1", 4, 30);
        chk_ent("t1_e0", 0, 32'h0000_0000, 32'hA500_0000);
        chk_ent("t1_e1", 1, 32'h0000_0004, 32'hA500_0004);
        chk_ent("t1_e2", 2, 32'h0000_0008, 32'hA500_0008);
        chk_ent("t1_e3", 3, 32'h0000_000C, 32'hA500_000C);
        if (cons_q.size() >= 4) begin
            chk("t1_spacing01", 32'(cons_q[1].cyc - cons_q[0].cyc), 32'd2);
            chk("t1_spacing23", 32'(cons_q[3].cyc - cons_q[2].cyc), 32'd2);
        end

        // 2: redirect while waiting for a response
        mem_lat = 2;
        do_reset();
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("t2_req_dropped", 32'(imem_req_valid), 32'd0);
        chk("t2_addr_target", imem_req_addr, 32'h0000_0100);
        tick();
        chk("t2_if_valid_kill", 32'(if_valid), 32'd0);
        chk("t2_reissue_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_reissue_addr", imem_req_addr, 32'h0000_0100);
        wait_log("t2", 1, 20);
        chk_ent("t2_e0", 0, 32'h0000_0100, 32'hA500_0100);

        // 3: decode stalls, output + skid fill
        mem_lat  = 1;
        if_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("t3_fires", 32'(fire_cnt), 32'd2);
        chk("t3_req_held_off", 32'(imem_req_valid), 32'd0);
        chk("t3_if_valid", 32'(if_valid), 32'd1);
        chk("t3_if_pc_stable", if_pc, 32'h0000_0000);
        chk("t3_if_instr_stable", if_instr, 32'hA500_0000);
        if_ready = 1'b1;
        wait_log("t3", 3, 20);
        chk_ent("t3_e0", 0, 32'h0000_0000, 32'hA500_0000);
        chk_ent("t3_e1", 1, 32'h0000_0004, 32'hA500_0004);
        chk_ent("t3_e2", 2, 32'h0000_0008, 32'hA500_0008);

        // 4: redirect to the top word, PC wraps to zero
        mem_lat = 1;
        do_reset();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_log("t4", 2, 20);
        chk_ent("t4_e0", 0, 32'hFFFF_FFFC, 32'h5AFF_FFFC);
        chk_ent("t4_e1", 1, 32'h0000_0000, 32'hA500_0000);

        // 5: memory not ready, redirect withdraws the request
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        chk("t5_c1_valid", 32'(imem_req_valid), 32'd1);
        tick();
        chk("t5_c2_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_c2_addr", imem_req_addr, 32'h0000_0000);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        chk("t5_c3_dropped", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t5_c4_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_c4_addr", imem_req_addr, 32'h0000_0200);
        tick();
        chk("t5_c5_addr", imem_req_addr, 32'h0000_0200);
        imem_req_ready = 1'b1;
        wait_log("t5", 1, 20);
        chk_ent("t5_e0", 0, 32'h0000_0200, 32'hA500_0200);

        // 6: asynchronous reset during an outstanding request
        mem_lat  = 3;
        if_ready = 1'b0;
        do_reset();
        repeat (7) tick();
        chk("t6_pre_if_valid", 32'(if_valid), 32'd1);
        chk("t6_pre_addr", imem_req_addr, 32'h0000_0004);
        reset_n = 1'b0;
        #1;
        chk("t6_async_if_valid", 32'(if_valid), 32'd0);
        chk("t6_async_if_instr", if_instr, 32'h0000_0013);
        chk("t6_async_addr", imem_req_addr, 32'h0000_0000);
        chk("t6_async_req", 32'(imem_req_valid), 32'd0);
        #1;
        reset_n  = 1'b1;
        if_ready = 1'b1;
        cons_q.delete();
        wait_log("t6", 1, 30);
        chk_ent("t6_e0", 0, 32'h0000_0000, 32'hA500_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
